// File: rtl/cla_adder.sv
// ---------------------------------------------------------------------------
// cla_adder
//   Registered WIDTH-bit two-level carry look-ahead adder:
//   {cout, s} = a + b + cin.
//   Inside each GROUP-bit group the carries are flattened sum-of-products of
//   the per-bit generate/propagate terms and the group carry-in. The group
//   carry-ins come from a second look-ahead level over the group
//   generate/propagate (GG/GP) terms, so no carry ripples from group to group.
//   The sum, carry-out and valid flag are captured in output flops, which
//   gives a fixed one-cycle latency and one result per cycle.
//
// Parameters
//   WIDTH  operand/sum width in bits (1..32)
//   GROUP  bits per look-ahead group; the last group may be partial
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   a, b       in   WIDTH-bit unsigned operands
//   cin        in   carry-in
//   in_valid   in   operands valid; when low the output flops hold
//   s          out  registered sum, a+b+cin mod 2^WIDTH
//   cout       out  registered carry-out
//   out_valid  out  high when s/cout were loaded by the preceding edge
//   ovf        out  registered two's-complement overflow (only when
//                   CLA_OVERFLOW_EN is defined)
//
// Configuration
//   CLA_OVERFLOW_EN  adds the ovf output, c[WIDTH] ^ c[WIDTH-1]
// ---------------------------------------------------------------------------
module cla_adder #(
    parameter int WIDTH = 3,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = (WIDTH + GROUP - 1) / GROUP;
    localparam int PW = NG * GROUP;

    logic [PW-1:0]    gx;
    logic [PW-1:0]    px;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    // Bits above WIDTH are padded with g=0, p=1: they neither generate nor
    // kill a carry, so a partial last group behaves exactly like a short
    // group and the group carry-out equals c[WIDTH].
    always_comb begin
        gx             = '0;
        px             = '1;
        gx[WIDTH-1:0]  = a & b;
        px[WIDTH-1:0]  = a ^ b;
    end

    // Group generate/propagate: GP is the AND of all propagates in the group,
    // GG is the flattened OR of each bit's generate qualified by every
    // propagate above it in the group.
    always_comb begin
        logic term;
        logic gg_acc;
        logic gp_acc;
        term   = 1'b0;
        gg     = '0;
        gp     = '0;
        for (int k = 0; k < NG; k++) begin
            gg_acc = 1'b0;
            gp_acc = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gp_acc = gp_acc & px[k*GROUP + j];
                term   = gx[k*GROUP + j];
                for (int m = j + 1; m < GROUP; m++) begin
                    term = term & px[k*GROUP + m];
                end
                gg_acc = gg_acc | term;
            end
            gg[k] = gg_acc;
            gp[k] = gp_acc;
        end
    end

    // Second look-ahead level: every group carry is its own flattened
    // sum-of-products over GG/GP and cin, never derived from the previous
    // group's carry.
    always_comb begin
        logic term;
        logic acc;
        term  = 1'b0;
        acc   = 1'b0;
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < NG; k++) begin
            acc = cin;
            for (int m = 0; m <= k; m++) begin
                acc = acc & gp[m];
            end
            for (int j = 0; j <= k; j++) begin
                term = gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & gp[m];
                end
                acc = acc | term;
            end
            gc[k+1] = acc;
        end
    end

    // Bit carries inside each group: the first bit takes the group carry,
    // the rest are flattened products of local g/p and the group carry-in.
    always_comb begin
        logic term;
        logic acc;
        int   base;
        int   j;
        term = 1'b0;
        acc  = 1'b0;
        base = 0;
        j    = 0;
        c    = '0;
        for (int idx = 0; idx < WIDTH; idx++) begin
            base = (idx / GROUP) * GROUP;
            j    = idx % GROUP;
            if (j == 0) begin
                c[idx] = gc[idx / GROUP];
            end else begin
                acc = gc[idx / GROUP];
                for (int m = 0; m < j; m++) begin
                    acc = acc & px[base + m];
                end
                for (int i = 0; i < j; i++) begin
                    term = gx[base + i];
                    for (int m = i + 1; m < j; m++) begin
                        term = term & px[base + m];
                    end
                    acc = acc | term;
                end
                c[idx] = acc;
            end
        end
    end

    always_comb begin
        sum       = px[WIDTH-1:0] ^ c;
        carry_out = gc[NG];
    end

    // Output stage: results load only on valid cycles; out_valid simply
    // mirrors in_valid one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= carry_out;
            end
        end
    end

`ifdef CLA_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= carry_out ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_adder
//   Self-checking bench for cla_adder at WIDTH=3, 8 and 13 (GROUP=4).
//   A plain-arithmetic reference model tracks the expected registered
//   outputs of each instance, including hold on in_valid=0 and reset.
//   Define CLA_OVERFLOW_EN to also check the ovf output.
// ---------------------------------------------------------------------------
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [2:0]  a3, b3, s3;
    logic        cin3, iv3, cout3, ov3;
    logic [7:0]  a8, b8, s8;
    logic        cin8, iv8, cout8, ov8;
    logic [12:0] a13, b13, s13;
    logic        cin13, iv13, cout13, ov13;
`ifdef CLA_OVERFLOW_EN
    logic        ovf3, ovf8, ovf13;
`endif

    // Expected registered state per instance: 0 -> W3, 1 -> W8, 2 -> W13
    logic [12:0] exp_s [3];
    logic        exp_c [3];
    logic        exp_v [3];
    logic        exp_o [3];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(3), .GROUP(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .cin(cin3), .in_valid(iv3),
        .s(s3), .cout(cout3), .out_valid(ov3)
`ifdef CLA_OVERFLOW_EN
        , .ovf(ovf3)
`endif
    );

    cla_adder #(.WIDTH(8), .GROUP(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .s(s8), .cout(cout8), .out_valid(ov8)
`ifdef CLA_OVERFLOW_EN
        , .ovf(ovf8)
`endif
    );

    cla_adder #(.WIDTH(13), .GROUP(4)) dut13 (
        .clk(clk), .rst_n(rst_n), .a(a13), .b(b13), .cin(cin13), .in_valid(iv13),
        .s(s13), .cout(cout13), .out_valid(ov13)
`ifdef CLA_OVERFLOW_EN
        , .ovf(ovf13)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: integer a+b+cin, carry is bit w, signed overflow is the
    // signed sum leaving the w-bit two's-complement range.
    task automatic modelUpdate(input int d, input int w, input longint x,
                               input longint y, input longint ci, input logic v);
        longint total, sx, sy, ss, half;
        exp_v[d] = v;
        if (v) begin
            half  = longint'(1) << (w - 1);
            total = x + y + ci;
            exp_s[d] = 13'(total % (longint'(1) << w));
            exp_c[d] = (total >= (longint'(1) << w));
            sx = (x >= half) ? x - 2 * half : x;
            sy = (y >= half) ? y - 2 * half : y;
            ss = sx + sy + ci;
            exp_o[d] = (ss > half - 1) || (ss < -half);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 3; d++) begin
            exp_s[d] = '0;
            exp_c[d] = 1'b0;
            exp_v[d] = 1'b0;
            exp_o[d] = 1'b0;
        end
    endtask

    function automatic logic [31:0] packExp(input int d);
`ifdef CLA_OVERFLOW_EN
        return {16'b0, exp_o[d], exp_v[d], exp_c[d], exp_s[d]};
`else
        return {16'b0, 1'b0, exp_v[d], exp_c[d], exp_s[d]};
`endif
    endfunction

    task automatic checkAll(input string tag);
        logic o3, o8, o13;
`ifdef CLA_OVERFLOW_EN
        o3 = ovf3; o8 = ovf8; o13 = ovf13;
`else
        o3 = 1'b0; o8 = 1'b0; o13 = 1'b0;
`endif
        checkOutput($sformatf("%s_w3", tag),  {16'b0, o3,  ov3,  cout3,  13'(s3)},  packExp(0));
        checkOutput($sformatf("%s_w8", tag),  {16'b0, o8,  ov8,  cout8,  13'(s8)},  packExp(1));
        checkOutput($sformatf("%s_w13", tag), {16'b0, o13, ov13, cout13, s13},      packExp(2));
    endtask

    // One cycle: drive at the falling edge, model at the rising edge,
    // compare 1 time unit later. ones_wide drives all-ones + 0 + cin=1 on the
    // wide instances to force a carry through every group.
    task automatic applyStimulus(input string tag, input logic [2:0] x, input logic [2:0] y,
                                 input logic ci, input logic v3, input logic v_wide,
                                 input logic ones_wide);
        @(negedge clk);
        a3 = x; b3 = y; cin3 = ci; iv3 = v3;
        iv8 = v_wide; iv13 = v_wide;
        if (ones_wide) begin
            a8  = '1; b8  = '0; cin8  = 1'b1;
            a13 = '1; b13 = '0; cin13 = 1'b1;
        end else begin
            a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
            a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
        end
        @(posedge clk);
        modelUpdate(0, 3,  longint'(a3),  longint'(b3),  longint'(cin3),  iv3);
        modelUpdate(1, 8,  longint'(a8),  longint'(b8),  longint'(cin8),  iv8);
        modelUpdate(2, 13, longint'(a13), longint'(b13), longint'(cin13), iv13);
        #1;
        checkAll(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        a3 = '0; b3 = '0; cin3 = 1'b0; iv3 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;
        a13 = '0; b13 = '0; cin13 = 1'b0; iv13 = 1'b0;
        modelReset();

        #3;
        checkAll("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 3-bit sweep, back-to-back valid; wide instances random
        // with occasional idle cycles to exercise hold.
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    applyStimulus("exh", 3'(x), 3'(y), 1'(ci), 1'b1,
                                  ($urandom_range(0, 3) != 0), 1'b0);
                end
            end
        end

        // Corners
        applyStimulus("corner_a", 3'd3, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("corner_3_5_0", {28'b0, cout3, s3}, 32'b1_000);
        applyStimulus("corner_b", 3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("corner_7_7_1", {28'b0, cout3, s3}, 32'b1_111);
        checkOutput("ones_w8", {23'b0, cout8, s8}, 32'h100);
        checkOutput("ones_w13", {18'b0, cout13, s13}, 32'h2000);
        applyStimulus("corner_c", 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("corner_0_0_0", {28'b0, cout3, s3}, 32'b0_000);
        applyStimulus("corner_d", 3'd7, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("corner_7_0_1", {28'b0, cout3, s3}, 32'b1_000);

        // Hold: in_valid low must keep the previous result
        applyStimulus("hold_load", 3'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("hold_idle", 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_w3", {27'b0, ov3, cout3, s3}, 32'b0_0_011);

`ifdef CLA_OVERFLOW_EN
        applyStimulus("ovf_a", 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ovf_3_1", {28'b0, ovf3, s3}, 32'b1_100);
        applyStimulus("ovf_b", 3'd4, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ovf_4_4", {27'b0, ovf3, cout3, s3}, 32'b1_1_000);
        applyStimulus("ovf_c", 3'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ovf_2_1", {31'b0, ovf3}, 32'b0);
`endif

        // Wide sweep with a mix of random and all-ones+cin patterns
        for (int n = 0; n < 60; n++) begin
            applyStimulus("wide", 3'($urandom), 3'($urandom), 1'($urandom),
                          ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                          (n % 10 == 0));
        end

        // Mid-stream asynchronous reset discards the in-flight result
        applyStimulus("pre_rst", 3'd5, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        a3 = 3'd3; b3 = 3'd3; cin3 = 1'b1; iv3 = 1'b1; iv8 = 1'b1; iv13 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        iv3 = 1'b0; iv8 = 1'b0; iv13 = 1'b0;
        applyStimulus("post_rst", 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("no_recover", {27'b0, ov3, cout3, s3}, 32'b0);

        // Resume normal operation after reset
        for (int n = 0; n < 8; n++) begin
            applyStimulus("resume", 3'($urandom), 3'($urandom), 1'($urandom),
                          1'b1, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
